// File: rtl/tow_pkg.sv
// ---------------------------------------------------------------------------
// tow_pkg
// Shared definitions for the tug-of-war handshake blocks.
//   hs_state_t   : state encoding of the 4-phase request/acknowledge sender
//   timer_width  : width of a phase timer that must be able to hold `cycles`
// ---------------------------------------------------------------------------
package tow_pkg;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_REQ     = 2'd1,
        S_RELEASE = 2'd2
    } hs_state_t;

    // A timer sized $clog2(cycles+1). When the timeout is disabled (cycles==0)
    // the timer is never used, so a minimum width of 1 bit keeps every vector legal.
    function automatic int timer_width(input int cycles);
        return (cycles > 0) ? $clog2(cycles + 1) : 1;
    endfunction

endpackage

// File: rtl/sync_ff_chain.sv
// ---------------------------------------------------------------------------
// sync_ff_chain
// Multi-flop synchronizer that brings an asynchronous level into the clk
// domain. All flops clear on reset, so the output is a clean 0 until the
// input has been sampled STAGES times.
// Ports:
//   clk    in  1  sampling clock (posedge)
//   reset  in  1  synchronous, active-high; clears every stage
//   d      in  1  asynchronous input level
//   q      out 1  d delayed by STAGES rising edges of clk
// Parameters:
//   STAGES  number of flops in the chain; must be >= 2
// ---------------------------------------------------------------------------
module sync_ff_chain #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    // Stage 0 takes the raw input; each later stage samples the one before it.
    always_ff @(posedge clk) begin
        if (reset) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/async_event_sender.sv
// ---------------------------------------------------------------------------
// async_event_sender
// Source end of a 4-phase req/ack handshake that carries single-cycle events
// out of the clk domain to an asynchronous peer. Local event pulses are
// queued in a saturating counter; one handshake is run per queued event.
// Ports:
//   clk          in   1       system clock, posedge
//   reset        in   1       synchronous, active-high
//   event_in     in   1       each high cycle is one event
//   ack_async    in   1       peer acknowledge, asynchronous to clk
//   req_out      out  1       registered request to the peer
//   busy         out  1       high while the handshake FSM is not idle
//   pending      out  PEND_W  events queued but not yet started
//   sent_pulse   out  1       one cycle on normal handshake completion
//   overflow     out  1       sticky: an event was dropped at saturation
//   timeout_err  out  1       sticky: a handshake phase ran too long
// Parameters:
//   SYNC_STAGES     flops in the ack synchronizer (>= 2)
//   PEND_W          pending counter width; holds up to 2**PEND_W-1 events
//   TIMEOUT_CYCLES  cycles allowed per handshake phase; 0 disables timeout
// ---------------------------------------------------------------------------
module async_event_sender
    import tow_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int PEND_W         = 4,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              event_in,
    input  logic              ack_async,
    output logic              req_out,
    output logic              busy,
    output logic [PEND_W-1:0] pending,
    output logic              sent_pulse,
    output logic              overflow,
    output logic              timeout_err
);

    localparam int                TW         = timer_width(TIMEOUT_CYCLES);
    localparam bit                TIMEOUT_EN = (TIMEOUT_CYCLES > 0);
    localparam logic [PEND_W-1:0] PEND_MAX   = '1;
    localparam logic [TW-1:0]     TIMER_LAST = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    hs_state_t     state;
    logic          ack_s;
    logic [TW-1:0] timer;
    logic          lost;
    logic          queue_full;
    logic          accept;
    logic          dequeue;
    logic          timer_hit;

    sync_ff_chain #(
        .STAGES (SYNC_STAGES)
    ) u_ack_sync (
        .clk   (clk),
        .reset (reset),
        .d     (ack_async),
        .q     (ack_s)
    );

    // The timer holds the number of completed cycles in the current phase, so
    // the phase has lasted TIMEOUT_CYCLES cycles at the edge where it reads
    // TIMEOUT_CYCLES-1.
    always_comb begin
        queue_full = (pending == PEND_MAX);
        accept     = event_in && !queue_full;
        dequeue    = (state == S_IDLE) && (pending != '0);
        timer_hit  = TIMEOUT_EN && (timer == TIMER_LAST);
    end

    assign busy = (state != S_IDLE);

    // Saturating event queue. A simultaneous accept and dequeue cancel out.
    always_ff @(posedge clk) begin
        if (reset) begin
            pending  <= '0;
            overflow <= 1'b0;
        end else begin
            if (event_in && queue_full) begin
                overflow <= 1'b1;
            end
            case ({accept, dequeue})
                2'b10:   pending <= pending + 1'b1;
                2'b01:   pending <= pending - 1'b1;
                default: pending <= pending;
            endcase
        end
    end

    // Handshake FSM with phase timer. `lost` marks a handshake whose request
    // phase timed out; its eventual release must not report completion.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            req_out     <= 1'b0;
            sent_pulse  <= 1'b0;
            timer       <= '0;
            lost        <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            sent_pulse <= 1'b0;
            case (state)
                S_IDLE: begin
                    timer <= '0;
                    if (pending != '0) begin
                        state   <= S_REQ;
                        req_out <= 1'b1;
                        lost    <= 1'b0;
                    end
                end
                S_REQ: begin
                    if (ack_s) begin
                        state   <= S_RELEASE;
                        req_out <= 1'b0;
                        timer   <= '0;
                    end else if (timer_hit) begin
                        state       <= S_RELEASE;
                        req_out     <= 1'b0;
                        timer       <= '0;
                        lost        <= 1'b1;
                        timeout_err <= 1'b1;
                    end else if (TIMEOUT_EN) begin
                        timer <= timer + 1'b1;
                    end
                end
                S_RELEASE: begin
                    if (!ack_s) begin
                        state      <= S_IDLE;
                        sent_pulse <= !lost;
                        timer      <= '0;
                    end else if (timer_hit) begin
                        // Stay here until the peer lets go; restart the timer
                        // so it never wraps while waiting.
                        timeout_err <= 1'b1;
                        timer       <= '0;
                    end else if (TIMEOUT_EN) begin
                        timer <= timer + 1'b1;
                    end
                end
                default: begin
                    state   <= S_IDLE;
                    req_out <= 1'b0;
                    timer   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_async_event_sender.sv
// ---------------------------------------------------------------------------
// tb_async_event_sender
// Directed bench for async_event_sender. Instance A uses the default
// parameters; instance B uses a 2-bit queue and a 20-cycle phase timeout.
// Completions of instance A are matched against a scoreboard of event ids.
// ---------------------------------------------------------------------------
module tb_async_event_sender;

    localparam int SYNC   = 2;
    localparam int PEND_A = 4;
    localparam int PEND_B = 2;
    localparam int TO_B   = 20;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A signals; its ack can come from a manual drive or an auto peer.
    logic              reset_a = 1'b1;
    logic              event_a = 1'b0;
    logic              auto_a = 1'b0;
    logic              ack_man_a = 1'b0;
    logic              ack_auto_a = 1'b0;
    logic              ack_a;
    logic              req_a, busy_a, sent_a, overflow_a, tout_a;
    logic [PEND_A-1:0] pending_a;

    // Instance B signals.
    logic              reset_b = 1'b1;
    logic              event_b = 1'b0;
    logic              ack_b = 1'b0;
    logic              req_b, busy_b, sent_b, overflow_b, tout_b;
    logic [PEND_B-1:0] pending_b;

    int check_count = 0;
    int pass_count  = 0;
    int fail_count  = 0;
    int sb[$];
    int next_id     = 0;
    int sent_seen_a = 0;
    int sent_cnt_b  = 0;

    assign ack_a = auto_a ? ack_auto_a : ack_man_a;

    async_event_sender #(
        .SYNC_STAGES    (SYNC),
        .PEND_W         (PEND_A),
        .TIMEOUT_CYCLES (1000)
    ) dut_a (
        .clk         (clk),
        .reset       (reset_a),
        .event_in    (event_a),
        .ack_async   (ack_a),
        .req_out     (req_a),
        .busy        (busy_a),
        .pending     (pending_a),
        .sent_pulse  (sent_a),
        .overflow    (overflow_a),
        .timeout_err (tout_a)
    );

    async_event_sender #(
        .SYNC_STAGES    (SYNC),
        .PEND_W         (PEND_B),
        .TIMEOUT_CYCLES (TO_B)
    ) dut_b (
        .clk         (clk),
        .reset       (reset_b),
        .event_in    (event_b),
        .ack_async   (ack_b),
        .req_out     (req_b),
        .busy        (busy_b),
        .pending     (pending_b),
        .sent_pulse  (sent_b),
        .overflow    (overflow_b),
        .timeout_err (tout_b)
    );

    // Auto peer: acknowledge follows request one clock later.
    always @(posedge clk) ack_auto_a <= req_a;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        check_count++;
        assert (obs === exp) pass_count++;
        else begin
            fail_count++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drive event_in high for n consecutive cycles; optionally record each
    // event as an expected completion. Reports the highest pending seen.
    task automatic applyStimulus(input bit sel_b, input int n, input bit score, output int peak);
        peak = 0;
        if (sel_b) event_b = 1'b1;
        else       event_a = 1'b1;
        for (int i = 0; i < n; i++) begin
            if (score) begin
                sb.push_back(next_id);
                next_id++;
            end
            tick(1);
            if (sel_b) peak = (int'(pending_b) > peak) ? int'(pending_b) : peak;
            else       peak = (int'(pending_a) > peak) ? int'(pending_a) : peak;
        end
        event_a = 1'b0;
        event_b = 1'b0;
    endtask

    // Scoreboard and completion monitors, sampled on the falling edge.
    always @(negedge clk) begin
        if (!reset_a && sent_a) begin
            if (sb.size() == 0) begin
                checkOutput("sb_unexpected_sent", 32'd1, 32'd0);
            end else begin
                checkOutput("sb_sent_order", sb.pop_front(), sent_seen_a);
            end
            sent_seen_a++;
        end
        if (!reset_b && sent_b) sent_cnt_b++;
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        int pk;
        bit tout_before;

        // Reset state
        tick(2);
        checkOutput("rst_req", req_a, 0);
        checkOutput("rst_busy", busy_a, 0);
        checkOutput("rst_pending", pending_a, 0);
        checkOutput("rst_sent", sent_a, 0);
        checkOutput("rst_overflow", overflow_a, 0);
        checkOutput("rst_timeout", tout_a, 0);
        checkOutput("rst_req_b", req_b, 0);
        reset_a = 1'b0;
        reset_b = 1'b0;
        tick(1);

        // Test 1: single event, manual peer
        $display("[TB] test 1: single handshake");
        applyStimulus(0, 1, 1, pk);
        checkOutput("t1_pending_n1", pending_a, 1);
        checkOutput("t1_req_n1", req_a, 0);
        tick(1);
        checkOutput("t1_req_n2", req_a, 1);
        checkOutput("t1_pending_n2", pending_a, 0);
        checkOutput("t1_busy_n2", busy_a, 1);
        tick(3);
        ack_man_a = 1'b1;
        n = 0;
        while (n < 20 && req_a) begin
            tick(1);
            n++;
        end
        // Two synchronizer edges, then one edge for the FSM to drop req.
        checkOutput("t1_req_fall_edges", n, SYNC + 1);
        ack_man_a = 1'b0;
        n = 0;
        while (n < 20 && busy_a) begin
            tick(1);
            n++;
        end
        checkOutput("t1_idle_in_budget", n < 20, 1);
        checkOutput("t1_sent_on_idle", sent_a, 1);
        tick(1);
        checkOutput("t1_sent_single", sent_a, 0);
        checkOutput("t1_pending_end", pending_a, 0);
        checkOutput("t1_sent_count", sent_seen_a, 1);

        // Test 2: five back-to-back events, auto peer
        $display("[TB] test 2: burst of five");
        auto_a = 1'b1;
        applyStimulus(0, 5, 1, pk);
        checkOutput("t2_peak_pending", pk, 4);
        n = 0;
        while (n < 300 && !(sb.size() == 0 && !busy_a && pending_a == 0)) begin
            tick(1);
            n++;
        end
        checkOutput("t2_drain_in_budget", n < 300, 1);
        tick(2);
        checkOutput("t2_sent_count", sent_seen_a, 6);
        checkOutput("t2_overflow", overflow_a, 0);
        auto_a = 1'b0;
        tick(4);

        // Overflow at the default width, then reset clears the sticky flag
        $display("[TB] saturation at PEND_W=4");
        applyStimulus(0, 16, 0, pk);
        checkOutput("ovf_a_pending_full", pending_a, 15);
        checkOutput("ovf_a_not_yet", overflow_a, 0);
        applyStimulus(0, 1, 0, pk);
        checkOutput("ovf_a_set", overflow_a, 1);
        checkOutput("ovf_a_pending_sat", pending_a, 15);
        reset_a = 1'b1;
        tick(1);
        checkOutput("ovf_a_cleared", overflow_a, 0);
        reset_a = 1'b0;
        tick(2);

        // Test 3: PEND_W=2, silent peer. One event goes in flight, three queue,
        // the next one is dropped.
        $display("[TB] test 3: saturation at PEND_W=2");
        applyStimulus(1, 4, 0, pk);
        checkOutput("t3_pending_sat", pending_b, 3);
        checkOutput("t3_in_flight", req_b, 1);
        checkOutput("t3_no_overflow_yet", overflow_b, 0);
        applyStimulus(1, 1, 0, pk);
        checkOutput("t3_overflow", overflow_b, 1);
        checkOutput("t3_pending_held", pending_b, 3);

        // Test 4: request phase timeout
        $display("[TB] test 4: REQ timeout");
        reset_b = 1'b1;
        tick(1);
        reset_b = 1'b0;
        sent_cnt_b = 0;
        applyStimulus(1, 1, 0, pk);
        tick(1);
        checkOutput("t4_req_up", req_b, 1);
        n = 0;
        tout_before = 1'b0;
        while (n < 60 && req_b) begin
            tout_before = tout_b;
            tick(1);
            n++;
        end
        checkOutput("t4_req_cycles", n, TO_B);
        checkOutput("t4_tout_not_early", tout_before, 0);
        checkOutput("t4_tout_set", tout_b, 1);
        checkOutput("t4_busy_release", busy_b, 1);
        tick(1);
        checkOutput("t4_idle_next", busy_b, 0);
        tick(3);
        checkOutput("t4_no_sent", sent_cnt_b, 0);

        // Test 5: ack stuck high, release phase timeout
        $display("[TB] test 5: RELEASE timeout");
        reset_b = 1'b1;
        tick(1);
        reset_b = 1'b0;
        applyStimulus(1, 1, 0, pk);
        tick(1);
        ack_b = 1'b1;
        tick(SYNC + 1);
        checkOutput("t5_req_dropped", req_b, 0);
        applyStimulus(1, 2, 0, pk);
        checkOutput("t5_pending_queued", pending_b, 2);
        n = 0;
        while (n < 60 && !tout_b) begin
            tick(1);
            n++;
        end
        checkOutput("t5_tout_in_budget", n < 60, 1);
        tick(5);
        checkOutput("t5_req_held_low", req_b, 0);
        checkOutput("t5_pending_held", pending_b, 2);
        checkOutput("t5_still_busy", busy_b, 1);
        ack_b = 1'b0;
        n = 0;
        while (n < 20 && !req_b) begin
            tick(1);
            n++;
        end
        checkOutput("t5_resumed", req_b, 1);
        checkOutput("t5_pending_after", pending_b, 1);

        // Test 6: reset in the middle of a handshake with events queued
        $display("[TB] test 6: reset mid-handshake");
        applyStimulus(0, 3, 0, pk);
        checkOutput("t6_pre_req", req_a, 1);
        checkOutput("t6_pre_pending", pending_a, 2);
        reset_a = 1'b1;
        tick(1);
        checkOutput("t6_req", req_a, 0);
        checkOutput("t6_pending", pending_a, 0);
        checkOutput("t6_busy", busy_a, 0);
        checkOutput("t6_overflow", overflow_a, 0);
        checkOutput("t6_timeout", tout_a, 0);
        reset_a = 1'b0;
        tick(5);
        checkOutput("t6_stays_idle", busy_a, 0);
        checkOutput("sb_empty_end", sb.size(), 0);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
